// File: rtl/tdm_demux.sv
// TDM serial receiver: hunts for frame sync, deserialises MSB-first slots and
// routes each completed word into a per-channel valid/ready holding register.
module tdm_demux #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din,
  input  logic                   din_en,
  input  logic                   sync,
  output logic [NCH*WIDTH-1:0]   ch_data,
  output logic [NCH-1:0]         ch_valid,
  input  logic [NCH-1:0]         ch_ready,
  output logic [NCH-1:0]         ovf,
  input  logic                   ovf_clr,
  output logic                   frame_err,
  output logic                   locked
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned SW = $clog2(NCH);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [WIDTH-1:0]            shreg_q, shreg_d;
  logic [BW-1:0]               bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]               slot_q, slot_d;
  logic [NCH-1:0][WIDTH-1:0]   data_q, data_d;
  logic [NCH-1:0]              valid_q, valid_d;
  logic [NCH-1:0]              ovf_q, ovf_d;
  logic                        frame_err_q, frame_err_d;
  logic                        locked_q;

  logic                        at_start;
  logic                        done;
  logic                        hit;
  logic [WIDTH-1:0]            shifted;
  logic [WIDTH-1:0]            restart;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      slot_q      <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      ovf_q       <= '0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_q      <= slot_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
      locked_q    <= (state_d == RUN);
    end
  end

  // Alignment FSM, deserialiser and per-channel holding registers
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    slot_d      = slot_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    hit         = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;

    at_start = (bit_cnt_q == '0) && (slot_q == '0);
    shifted  = {shreg_q[WIDTH-2:0], din};
    restart  = {{(WIDTH-1){1'b0}}, din};

    case (state_q)
      HUNT: begin
        if (din_en && sync) begin
          state_d   = RUN;
          shreg_d   = restart;
          bit_cnt_d = BW'(1);
          slot_d    = '0;
        end
      end
      RUN: begin
        if (din_en) begin
          if (sync && !at_start) begin
            // Early sync: drop the partial word and realign on this bit
            frame_err_d = 1'b1;
            shreg_d     = restart;
            bit_cnt_d   = BW'(1);
            slot_d      = '0;
          end else if (!sync && at_start) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else begin
            shreg_d = shifted;
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
              done      = 1'b1;
              bit_cnt_d = '0;
              slot_d    = (slot_q == SW'(NCH - 1)) ? '0 : slot_q + SW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // A drain and a load in the same cycle leave the channel full with the new word
    for (int c = 0; c < int'(NCH); c++) begin
      hit      = done && (slot_q == SW'(c));
      ovf_d[c] = ovf_q[c] & ~ovf_clr;
      if (valid_q[c] && ch_ready[c]) valid_d[c] = 1'b0;
      if (hit) begin
        if (!valid_q[c] || ch_ready[c]) begin
          data_d[c]  = shifted;
          valid_d[c] = 1'b1;
        end else begin
          ovf_d[c] = 1'b1;
        end
      end
    end
  end

  assign ch_data   = data_q;
  assign ch_valid  = valid_q;
  assign ovf       = ovf_q;
  assign frame_err = frame_err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=2, WIDTH=8) with hand-computed expectations.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_en;
  logic        sync;
  logic [15:0] ch_data;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_ready;
  logic [1:0]  ovf;
  logic        ovf_clr;
  logic        frame_err;
  logic        locked;

  int total = 0;
  int bad   = 0;

  tdm_demux #(.NCH(2), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_en    (din_en),
    .sync      (sync),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    din    = b;
    sync   = s;
    din_en = 1'b1;
    @(posedge clk);
    #1;
    din_en = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic idle();
    din_en = 1'b0;
    sync   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic first_sync);
    for (int i = 7; i >= 0; i--) send_bit(w[i], first_sync && (i == 7));
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1);
    send_word(w0, 1'b1);
    send_word(w1, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    rst_n    = 1'b0;
    din      = 1'b0;
    din_en   = 1'b0;
    sync     = 1'b0;
    ch_ready = 2'b00;
    ovf_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",   32'(ch_data),   32'h0);
    chk("rst_valid",  32'(ch_valid),  32'h0);
    chk("rst_ovf",    32'(ovf),       32'h0);
    chk("rst_locked", 32'(locked),    32'h0);
    chk("rst_ferr",   32'(frame_err), 32'h0);
    rst_n = 1'b1;
    idle();

    // Lock and deliver
    ch_ready = 2'b11;
    w = 8'hA5;
    send_bit(w[7], 1'b1);
    chk("t1_locked", 32'(locked), 32'h1);
    chk("t1_ferr",   32'(frame_err), 32'h0);
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("t1_d0",  32'(ch_data[7:0]), 32'hA5);
    chk("t1_v0",  32'(ch_valid[0]),  32'h1);
    send_word(8'h3C, 1'b0);
    chk("t1_d1",  32'(ch_data[15:8]), 32'h3C);
    chk("t1_v",   32'(ch_valid),      32'h2);
    idle();
    chk("t1_drain", 32'(ch_valid), 32'h0);
    chk("t1_ferr2", 32'(frame_err), 32'h0);

    // Backpressure and overflow
    ch_ready = 2'b10;
    send_frame(8'h11, 8'h00);
    send_frame(8'h22, 8'h00);
    chk("t2_d0",  32'(ch_data[7:0]), 32'h11);
    chk("t2_v0",  32'(ch_valid[0]),  32'h1);
    chk("t2_ovf", 32'(ovf),          32'h1);
    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    chk("t2_ovfclr", 32'(ovf), 32'h0);

    // Same-cycle drain and load on channel 1
    ch_ready = 2'b01;
    idle();
    chk("t3_v0clr", 32'(ch_valid), 32'h0);
    send_frame(8'h01, 8'h55);
    chk("t3_hold", 32'(ch_data[15:8]), 32'h55);
    send_word(8'h02, 1'b1);
    w = 8'h77;
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    ch_ready = 2'b11;
    send_bit(w[0], 1'b0);
    ch_ready = 2'b01;
    chk("t3_d1",  32'(ch_data[15:8]), 32'h77);
    chk("t3_v1",  32'(ch_valid[1]),   32'h1);
    chk("t3_ovf", 32'(ovf),           32'h0);
    ch_ready = 2'b11;
    idle();
    chk("t3_drain", 32'(ch_valid), 32'h0);

    // Missing sync, then resync
    send_frame(8'h12, 8'h34);
    send_bit(1'b0, 1'b0);
    chk("t4_ferr",   32'(frame_err), 32'h1);
    chk("t4_unlock", 32'(locked),    32'h0);
    idle();
    chk("t4_ferr_pulse", 32'(frame_err), 32'h0);
    send_word(8'hFF, 1'b0);
    chk("t4_nodata", 32'(ch_data), 32'h3412);
    chk("t4_novalid", 32'(ch_valid), 32'h0);
    send_frame(8'h0F, 8'hF0);
    chk("t4_resync", 32'(ch_data), 32'hF00F);
    chk("t4_locked", 32'(locked),  32'h1);

    // Early sync at bit 5 of slot 0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    w = 8'h81;
    send_bit(w[7], 1'b1);
    chk("t5_ferr",   32'(frame_err), 32'h1);
    chk("t5_locked", 32'(locked),    32'h1);
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("t5_d0",   32'(ch_data[7:0]), 32'h81);
    chk("t5_ferr0", 32'(frame_err),   32'h0);
    send_word(8'h18, 1'b0);
    chk("t5_data", 32'(ch_data), 32'h1881);
    idle();

    // Reset mid-frame at bit 3 of slot 1
    ch_ready = 2'b00;
    send_word(8'h5A, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t6_pre_valid", 32'(ch_valid), 32'h1);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("t6_data",   32'(ch_data),  32'h0);
    chk("t6_valid",  32'(ch_valid), 32'h0);
    chk("t6_ovf",    32'(ovf),      32'h0);
    chk("t6_locked", 32'(locked),   32'h0);
    ch_ready = 2'b11;
    w = 8'hC3;
    send_bit(w[7], 1'b1);
    chk("t6_relock", 32'(locked), 32'h1);
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    send_word(8'h3C, 1'b0);
    chk("t6_frame", 32'(ch_data), 32'h3CC3);
    chk("t6_ferr",  32'(frame_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side counterpart of the channel multiplexer. The block takes a time-division-multiplexed serial bit stream with a frame sync, hunts for frame alignment, and deserialises each slot into a WIDTH-bit word. Each word is routed to its own per-channel holding register, which is drained through a valid/ready handshake. It sits between the serial link input and the per-channel consumers.

## Interface
- NCH, 2: number of channels (slots per frame), ≥2
- WIDTH, 8: bits per slot, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock, synchronous active-low reset (fixed)
- din  in  1  serial data bit, MSB of each slot first
- din_en  in  1  din/sync qualify strobe; bits with din_en=0 are ignored
- sync  in  1  frame sync, qualified by din_en, marks first bit of slot 0
- ch_data  out  NCH*WIDTH  channel c word at [c*WIDTH +: WIDTH]
- ch_valid  out  NCH  channel c holding register full
- ch_ready  in  NCH  consumer c accepts word when ch_valid[c]&ch_ready[c]
- ovf  out  NCH  sticky: word for channel c dropped because holding register full
- ovf_clr  in  1  clears all ovf bits
- frame_err  out  1  one-cycle pulse on alignment error
- locked  out  1  1 while in RUN state

## Operation
- States: HUNT, RUN. Reset -> HUNT.
- HUNT: qualified bits with sync=0 are discarded. A qualified bit with sync=1 enters RUN, is shifted in as bit 0 of slot 0, and sets bit_cnt=1, slot=0.
- RUN: each qualified bit shifts into shreg (MSB first) and increments bit_cnt.
  - When bit_cnt reaches WIDTH, the word is complete: bit_cnt→0, slot→slot+1, wrapping NCH-1→0.
- Word completion for slot s:
  - if ch_valid[s]=0, or ch_ready[s]=1 in the same cycle: load ch_data[s], set ch_valid[s]=1.
  - otherwise: drop the word, keep the old data, set ovf[s]=1.
- Frame checks in RUN, at a qualified bit:
  - bit_cnt=0, slot=0, sync=0 (missing sync): pulse frame_err, go to HUNT, discard the bit.
  - sync=1 while not (bit_cnt=0 and slot=0) (early sync): pulse frame_err, discard the partial word, then restart with this bit as bit 0 of slot 0; stay in RUN.
  - Partial words never reach outputs.
- Handshake: ch_valid[c] holds until ch_valid[c]&ch_ready[c]. It then clears, unless a completion for c occurs in the same cycle, in which case the new word loads and valid stays 1 with no ovf.
- ch_data[c] is stable while ch_valid[c]=1. Holding registers keep their contents across HUNT.
- ovf_clr clears all ovf bits. If ovf_clr coincides with a new overflow on channel c, ovf[c] ends at 1 (set wins).
- Widths: bit_cnt is clog2(WIDTH+1) bits, slot is clog2(NCH) bits; no arithmetic beyond increment/wrap.

## Timing
- Reset values: ch_data=0, ch_valid=0, ovf=0, frame_err=0, locked=0, shreg=0, bit_cnt=0, slot=0.
- Reset asserted mid-frame: all state returns to reset values on that edge, including dropping held words. The first qualified sync after release is accepted.
- Latency: ch_valid[s] rises on the clock edge that samples the last qualified bit of slot s; the word is visible in the following cycle.
- locked rises on the edge sampling the accepting sync bit. It falls on the edge sampling a missing-sync bit.
- frame_err is high for exactly the one cycle after the offending edge.
- Back-to-back din_en=1 is supported at full rate with no bubbles. Gaps in din_en stall all counters.
- ch_ready is sampled only when ch_valid=1. A consumer holding ch_ready=1 permanently never causes ovf.

## Test plan
- Lock and deliver (NCH=2, WIDTH=8): continuous din_en, sync on first bit, stream 0xA5 then 0x3C, ch_ready=11 -> ch_data[7:0]=A5 one cycle after bit 8, ch_data[15:8]=3C one cycle after bit 16, locked=1, no frame_err.
- Backpressure/overflow: ch_ready[0]=0, send two frames with slot 0 = 0x11, then 0x22 -> ch_data[7:0] stays 11, ch_valid[0]=1, ovf[0]=1; pulse ovf_clr -> ovf=00.
- Same-cycle drain and load: ch_ready[1] pulsed exactly on the completion cycle of slot 1 word 0x77 while holding 0x55 -> ch_data[15:8]=77, ch_valid[1]=1, ovf[1]=0.
- Missing sync: after one good frame, next frame's first bit has sync=0 -> frame_err one-cycle pulse, locked=0, no new words; resync with sync=1 on 0x0F frame -> ch_data[7:0]=0F.
- Early sync: sync=1 at bit 5 of slot 0 -> frame_err pulse, partial word discarded, realigned frame 0x81/0x18 delivered correctly.
- Reset mid-frame: rst_n=0 for one cycle at bit 3 of slot 1 with ch_valid=01 -> all outputs 0, locked=0. The next sync frame 0xC3/0x3C is delivered normally.
